// File: rtl/seg_pkg.sv
// Shared 7-segment constants and helpers for the display path and the game controller.
// Glyphs are active-low with bit order [6:0] = g..a.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam seg_t        SEG_BLANK  = 7'h7F;
  localparam logic [3:0]  ANODE_OFF  = 4'hF;

  localparam seg_t GLYPH_0 = 7'h40;
  localparam seg_t GLYPH_1 = 7'h79;
  localparam seg_t GLYPH_2 = 7'h24;
  localparam seg_t GLYPH_3 = 7'h30;
  localparam seg_t GLYPH_4 = 7'h19;
  localparam seg_t GLYPH_5 = 7'h12;
  localparam seg_t GLYPH_6 = 7'h02;
  localparam seg_t GLYPH_7 = 7'h78;
  localparam seg_t GLYPH_8 = 7'h00;
  localparam seg_t GLYPH_9 = 7'h10;
  localparam seg_t GLYPH_H = 7'h09;
  localparam seg_t GLYPH_I = 7'h79;
  localparam seg_t GLYPH_L = 7'h47;
  localparam seg_t GLYPH_O = 7'h40;
  localparam seg_t GLYPH_S = 7'h12;
  localparam seg_t GLYPH_C = 7'h46;

  // A modulo-1 counter still needs one bit to exist as a signal.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display bus between the pattern source (master) and the multiplexing scanner (slave).
interface seven_seg_scan_if;
  import seg_pkg::*;

  seg_t       dig1;
  seg_t       dig2;
  seg_t       dig3;
  seg_t       dig4;
  logic [3:0] blink_mask;
  seg_t       seg;
  logic [3:0] an;
  logic       frame_tick;

  modport master (
    output dig1, dig2, dig3, dig4, blink_mask,
    input  seg, an, frame_tick
  );

  modport slave (
    input  dig1, dig2, dig3, dig4, blink_mask,
    output seg, an, frame_tick
  );

endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with enable; wrap flags the enabled cycle at the terminal count.
module mod_n_counter
  import seg_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (RESET) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexes four 7-seg patterns onto one cathode bus with blanking between digits,
// per-frame input snapshots and per-digit blinking.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input logic              clk,
  input logic              RESET,
  seven_seg_scan_if.slave  bus
);

  localparam int unsigned SLOT_W  = cnt_width(REFRESH_DIV);
  localparam int unsigned IDX_W   = cnt_width(NUM_DIGITS);
  localparam int unsigned FRAME_W = cnt_width(BLINK_FRAMES);

  logic [SLOT_W-1:0]  slot_cnt;
  logic [IDX_W-1:0]   idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               slot_wrap;
  logic               frame_end;
  logic               blink_wrap;

  seg_t       shadow_q [NUM_DIGITS];
  seg_t       seg_q;
  logic [3:0] an_q;
  logic       frame_tick_q;
  logic       phase_q;

  mod_n_counter #(.N(REFRESH_DIV)) u_slot_cnt (
    .clk   (clk),
    .RESET (RESET),
    .en    (1'b1),
    .count (slot_cnt),
    .wrap  (slot_wrap)
  );

  // The digit counter wraps exactly on the last cycle of the last slot: end of frame.
  mod_n_counter #(.N(NUM_DIGITS)) u_idx_cnt (
    .clk   (clk),
    .RESET (RESET),
    .en    (slot_wrap),
    .count (idx),
    .wrap  (frame_end)
  );

  mod_n_counter #(.N(BLINK_FRAMES)) u_frame_cnt (
    .clk   (clk),
    .RESET (RESET),
    .en    (frame_end),
    .count (frame_cnt),
    .wrap  (blink_wrap)
  );

  logic unused_frame_cnt;
  assign unused_frame_cnt = ^frame_cnt;

  logic blank;
  logic frame_start;
  assign blank       = slot_cnt < SLOT_W'(BLANK_CYCLES);
  assign frame_start = (slot_cnt == '0) && (idx == '0);

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= SEG_BLANK;
      seg_q        <= SEG_BLANK;
      an_q         <= ANODE_OFF;
      frame_tick_q <= 1'b0;
      phase_q      <= 1'b0;
    end else begin
      if (frame_start) begin
        shadow_q[0] <= bus.dig1;
        shadow_q[1] <= bus.dig2;
        shadow_q[2] <= bus.dig3;
        shadow_q[3] <= bus.dig4;
      end
      frame_tick_q <= frame_end;
      if (blink_wrap) phase_q <= ~phase_q;
      // Blanking at every slot start keeps two different anodes from ever abutting.
      if (blank) begin
        an_q  <= ANODE_OFF;
        seg_q <= SEG_BLANK;
      end else begin
        an_q  <= ~(4'b1000 >> idx);
        seg_q <= (phase_q && bus.blink_mask[2'd3 - idx]) ? SEG_BLANK : shadow_q[idx];
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with a small timing-expectation model keyed on the
// cycle count since reset release.
module tb_seven_seg_scan;
  import seg_pkg::*;

  localparam int unsigned RD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned BF    = 2;
  localparam int          FRAME = RD * NUM_DIGITS;

  logic clk = 1'b0;
  logic RESET;

  seven_seg_scan_if bus();

  seven_seg_scan #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         k     = -1;
  int         ft_cnt;
  string      test_name;
  seg_t       d [NUM_DIGITS];
  seg_t       exp_sh [NUM_DIGITS];
  logic [3:0] bm;
  logic [3:0] prev_an = 4'hF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // One clock: drive inputs, take the edge, then check outputs 1 time unit later.
  task automatic tick(input bit rst);
    logic [3:0] e_an;
    seg_t       e_seg;
    logic       e_ft;
    int         pos, sl, di;
    bit         ph;
    bus.dig1       = d[0];
    bus.dig2       = d[1];
    bus.dig3       = d[2];
    bus.dig4       = d[3];
    bus.blink_mask = bm;
    RESET          = rst;
    @(posedge clk);
    if (rst) begin
      k = -1;
      for (int i = 0; i < NUM_DIGITS; i++) exp_sh[i] = SEG_BLANK;
    end else begin
      k++;
      if (k % FRAME == 0) for (int i = 0; i < NUM_DIGITS; i++) exp_sh[i] = d[i];
    end
    #1;
    if (rst) begin
      e_an = 4'hF; e_seg = SEG_BLANK; e_ft = 1'b0;
    end else begin
      pos  = k % FRAME;
      sl   = pos % RD;
      di   = pos / RD;
      ph   = ((k / (FRAME * BF)) % 2) == 1;
      e_ft = (pos == FRAME - 1);
      if (sl < BC) begin
        e_an = 4'hF; e_seg = SEG_BLANK;
      end else begin
        e_an  = ~(4'b1000 >> di);
        e_seg = (ph && bm[3 - di]) ? SEG_BLANK : exp_sh[di];
      end
    end
    check_eq({test_name, "_an"}, 32'(bus.an), 32'(e_an));
    check_eq({test_name, "_seg"}, 32'(bus.seg), 32'(e_seg));
    check_eq({test_name, "_tick"}, 32'(bus.frame_tick), 32'(e_ft));
    check_eq("an_onehot0", 32'($countones(~bus.an) <= 1), 32'd1);
    check_eq("an_switch",
             32'((prev_an == 4'hF) || (bus.an == 4'hF) || (bus.an == prev_an)), 32'd1);
    if (bus.frame_tick === 1'b1) ft_cnt++;
    prev_an = bus.an;
  endtask

  initial begin
    d[0] = GLYPH_0; d[1] = GLYPH_1; d[2] = GLYPH_2; d[3] = GLYPH_3;
    bm   = 4'b0000;

    test_name = "reset";
    repeat (3) tick(1'b1);

    test_name = "scan";
    repeat (FRAME) tick(1'b0);

    // dig2 changes inside the idx 0 slot of frame 1; only frame 2 may show it.
    test_name = "snapshot";
    repeat (3) tick(1'b0);
    d[1] = 7'h12;
    repeat (2 * FRAME - 3) tick(1'b0);

    test_name = "frame_tick";
    ft_cnt = 0;
    repeat (2 * FRAME) tick(1'b0);
    check_eq("tick_count", 32'(ft_cnt), 32'd2);

    test_name = "blink";
    bm = 4'b0001;
    repeat (4 * FRAME) tick(1'b0);

    test_name = "midreset";
    for (int i = 0; i < FRAME && (k % FRAME) != 2 * RD + 5; i++) tick(1'b0);
    check_eq("reset_point", 32'(k % FRAME), 32'(2 * RD + 5));
    tick(1'b1);
    d[0] = GLYPH_5; d[1] = GLYPH_H; d[2] = GLYPH_L; d[3] = GLYPH_C;
    test_name = "restart";
    ft_cnt = 0;
    repeat (FRAME + 16) tick(1'b0);
    check_eq("restart_ticks", 32'(ft_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
